reg_write_arb: RTL and testbench

REG_WRITE_ARB -- requirements
Module: reg_write_arb

---
 rtl/reg_write_arb.sv | 175 +++++++++++++++++
 tb/tb_reg_write_arb.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arb
//  Description : Register-file write-port arbiter. Single-cycle ALU results
//                always win the write port. Long-latency (load, mul/div)
//                results wait in a small FIFO and drain whenever the ALU is
//                idle. When the FIFO is empty they bypass it with the same
//                one-cycle latency. A buffered entry whose destination is
//                overwritten by a winning ALU write is killed, so the stale
//                value never reaches the register file.
//  Ports       : clk, rst                     - clock, synchronous active-high reset
//                alu_we/alu_addr/alu_data     - ALU write request (no backpressure)
//                ext_valid/ext_addr/ext_data  - long-latency write request
//                ext_ready                    - ext request accepted when valid && ready
//                reg_we/reg_addr_3/reg_write  - registered register-file write port
//                fifo_count                   - number of buffered ext entries
//                chk_addr_n/chk_hit_n         - pending-write hazard lookup
//                                               (only with WB_HAZARD_EN)
//  Options     : define WB_HAZARD_EN to add the hazard lookup ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef N
`define N 31
`endif

module reg_write_arb #(
    parameter int reg_ad     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_we,
    input  logic [reg_ad:0]               alu_addr,
    input  logic [`N:0]                   alu_data,
    input  logic                          ext_valid,
    input  logic [reg_ad:0]               ext_addr,
    input  logic [`N:0]                   ext_data,
    output logic                          ext_ready,
    output logic                          reg_we,
    output logic [reg_ad:0]               reg_addr_3,
    output logic [`N:0]                   reg_write,
`ifdef WB_HAZARD_EN
    input  logic [reg_ad:0]               chk_addr_1,
    input  logic [reg_ad:0]               chk_addr_2,
    output logic                          chk_hit_1,
    output logic                          chk_hit_2,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int               c_PW   = $clog2(FIFO_DEPTH);
    localparam logic [c_PW:0]    c_FULL = FIFO_DEPTH[c_PW:0];

    logic [reg_ad:0]        r_fifo_addr [FIFO_DEPTH];
    logic [`N:0]            r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_valid;
    logic [FIFO_DEPTH-1:0]  r_kill;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW:0]          r_count;

    logic                   r_reg_we;
    logic [reg_ad:0]        r_reg_addr;
    logic [`N:0]            r_reg_data;

    logic w_full;
    logic w_empty;
    logic w_ext_acc;
    logic w_alu_win;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_push_kill;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle does not free a slot for the incoming request.
    assign ext_ready = !w_full && !rst;
    assign w_ext_acc = ext_valid && ext_ready;

    assign w_alu_win = !rst && alu_we && (alu_addr != '0);
    assign w_pop     = !rst && !w_alu_win && !w_empty;
    assign w_bypass  = !rst && !w_alu_win && w_empty && w_ext_acc && (ext_addr != '0);
    // Address-0 ext requests are accepted but dropped here.
    assign w_push    = w_ext_acc && (ext_addr != '0) && !w_bypass;
    // An ext result arriving alongside an ALU write to the same register is
    // the older value, so it enters the FIFO already dead.
    assign w_push_kill = w_alu_win && (alu_addr == ext_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_kill     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_reg_we   <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
        end else begin
            r_reg_we <= 1'b0;

            if (w_alu_win) begin
                r_reg_we   <= 1'b1;
                r_reg_addr <= alu_addr;
                r_reg_data <= alu_data;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (r_valid[i] && (r_fifo_addr[i] == alu_addr)) begin
                        r_kill[i] <= 1'b1;
                    end
                end
            end else if (w_pop) begin
                // Killed entries still drain in order, just without a write.
                if (!r_kill[r_rd_ptr]) begin
                    r_reg_we   <= 1'b1;
                    r_reg_addr <= r_fifo_addr[r_rd_ptr];
                    r_reg_data <= r_fifo_data[r_rd_ptr];
                end
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end else if (w_bypass) begin
                r_reg_we   <= 1'b1;
                r_reg_addr <= ext_addr;
                r_reg_data <= ext_data;
            end

            // The push slot is never live, so it cannot collide with the
            // kill marking above or with the pop slot.
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= ext_addr;
                r_fifo_data[r_wr_ptr] <= ext_data;
                r_valid[r_wr_ptr]     <= 1'b1;
                r_kill[r_wr_ptr]      <= w_push_kill;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign reg_we     = r_reg_we;
    assign reg_addr_3 = r_reg_addr;
    assign reg_write  = r_reg_data;
    assign fifo_count = r_count;

`ifdef WB_HAZARD_EN
    logic w_hit_1;
    logic w_hit_2;

    // A register is "pending" while a live, non-killed FIFO entry targets it
    // or while it is being written this cycle.
    always_comb begin
        w_hit_1 = 1'b0;
        w_hit_2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_valid[i] && !r_kill[i] && (r_fifo_addr[i] == chk_addr_1)) w_hit_1 = 1'b1;
            if (r_valid[i] && !r_kill[i] && (r_fifo_addr[i] == chk_addr_2)) w_hit_2 = 1'b1;
        end
        if (r_reg_we && (r_reg_addr == chk_addr_1)) w_hit_1 = 1'b1;
        if (r_reg_we && (r_reg_addr == chk_addr_2)) w_hit_2 = 1'b1;
        if (chk_addr_1 == '0) w_hit_1 = 1'b0;
        if (chk_addr_2 == '0) w_hit_2 = 1'b0;
    end

    assign chk_hit_1 = w_hit_1;
    assign chk_hit_2 = w_hit_2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arb
//  Description : Self-checking bench for reg_write_arb. Expected register-file
//                writes are queued as stimulus is driven; a monitor pops and
//                compares them whenever reg_we is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef N
`define N 31
`endif

module tb_reg_write_arb;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ext_valid;
    logic [4:0]  ext_addr;
    logic [31:0] ext_data;
    logic        ext_ready;
    logic        reg_we;
    logic [4:0]  reg_addr_3;
    logic [31:0] reg_write;
    logic [2:0]  fifo_count;
`ifdef WB_HAZARD_EN
    logic [4:0]  chk_addr_1;
    logic [4:0]  chk_addr_2;
    logic        chk_hit_1;
    logic        chk_hit_2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];
    wr_t ext_q[$];

    reg_write_arb #(.reg_ad(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_we     (alu_we),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ext_valid  (ext_valid),
        .ext_addr   (ext_addr),
        .ext_data   (ext_data),
        .ext_ready  (ext_ready),
        .reg_we     (reg_we),
        .reg_addr_3 (reg_addr_3),
        .reg_write  (reg_write),
`ifdef WB_HAZARD_EN
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .chk_hit_1  (chk_hit_1),
        .chk_hit_2  (chk_hit_2),
`endif
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(posedge clk) begin : mon
        wr_t e;
        #1;
        if (reg_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", reg_addr_3, reg_write);
            end else begin
                e = exp_q.pop_front();
                if (reg_addr_3 !== e.a || reg_write !== e.d) begin
                    n_fail++;
                    $display("FAIL write_order: got addr %0d data %h, required addr %0d data %h",
                             reg_addr_3, reg_write, e.a, e.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_we = 1'b0; alu_addr = '0; alu_data = '0;
        ext_valid = 1'b0; ext_addr = '0; ext_data = '0;
`ifdef WB_HAZARD_EN
        chk_addr_1 = '0; chk_addr_2 = '0;
`endif
        tick; tick;
        n_checks++;
        if (reg_we !== 1'b0 || reg_addr_3 !== 5'd0 || reg_write !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_port: got we %b addr %0d data %h, required 0 0 0", reg_we, reg_addr_3, reg_write);
        end
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, required 0", fifo_count);
        end
        n_checks++;
        if (ext_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 0", ext_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ext_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b, required 1", ext_ready);
        end
    endtask

    task automatic test_alu_write;
        alu_we = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        exp_q.push_back(wr_t'{5'd5, 32'h1234});
        tick;
        alu_we = 1'b0;
        n_checks++;
        if (reg_we !== 1'b1 || reg_addr_3 !== 5'd5 || reg_write !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_write: got we %b addr %0d data %h, required 1 5 00001234", reg_we, reg_addr_3, reg_write);
        end
    endtask

    task automatic test_bypass;
        n_checks++;
        if (ext_ready !== 1'b1) begin
            n_fail++; $display("FAIL bypass_ready: got %b, required 1", ext_ready);
        end
        ext_valid = 1'b1; ext_addr = 5'd7; ext_data = 32'hAA;
        exp_q.push_back(wr_t'{5'd7, 32'hAA});
        tick;
        ext_valid = 1'b0;
        n_checks++;
        if (reg_we !== 1'b1 || reg_addr_3 !== 5'd7 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_write: got we %b addr %0d count %0d, required 1 7 0", reg_we, reg_addr_3, fifo_count);
        end
    endtask

    task automatic test_starvation;
        int  ei;
        bit  acc;
        ei = 1;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) begin
                while (ext_q.size() > 0) exp_q.push_back(ext_q.pop_front());
            end
            if (c < 6) begin
                alu_we = 1'b1; alu_addr = 5'(16 + c); alu_data = 32'(32'h100 + c);
                exp_q.push_back(wr_t'{alu_addr, alu_data});
            end else begin
                alu_we = 1'b0;
            end
            if (ei <= 6) begin
                ext_valid = 1'b1; ext_addr = 5'(ei); ext_data = 32'(32'h200 + ei);
            end else begin
                ext_valid = 1'b0;
            end
            acc = ext_valid && ext_ready;
            if (c == 4) begin
                n_checks++;
                if (fifo_count !== 3'd4 || ext_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_full: got count %0d ready %b, required 4 0", fifo_count, ext_ready);
                end
            end
            tick;
            if (acc) begin
                if (c < 6) ext_q.push_back(wr_t'{ext_addr, ext_data});
                else       exp_q.push_back(wr_t'{ext_addr, ext_data});
                ei++;
            end
        end
        alu_we = 1'b0; ext_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL starve_drain: got count %0d pending %0d, required 0 0", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_kill;
        // Buffer ext 9 behind an ALU write, then overwrite it from the ALU.
        alu_we = 1'b1; alu_addr = 5'd10; alu_data = 32'h55;
        exp_q.push_back(wr_t'{5'd10, 32'h55});
        ext_valid = 1'b1; ext_addr = 5'd9; ext_data = 32'h11;
        tick;
        ext_valid = 1'b0;
        alu_addr = 5'd9; alu_data = 32'h22;
        exp_q.push_back(wr_t'{5'd9, 32'h22});
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL kill_buffered: got count %0d, required 1", fifo_count);
        end
        tick;
        alu_we = 1'b0;
        tick;
        n_checks++;
        if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL kill_pop: got we %b count %0d, required 0 0", reg_we, fifo_count);
        end
        // Same-cycle ALU and ext to one register: ext is the older value.
        alu_we = 1'b1; alu_addr = 5'd12; alu_data = 32'h33;
        exp_q.push_back(wr_t'{5'd12, 32'h33});
        ext_valid = 1'b1; ext_addr = 5'd12; ext_data = 32'h44;
        tick;
        alu_we = 1'b0; ext_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL same_cycle_push: got count %0d, required 1", fifo_count);
        end
        tick;
        n_checks++;
        if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL same_cycle_kill: got we %b count %0d, required 0 0", reg_we, fifo_count);
        end
    endtask

    task automatic test_addr_zero;
        alu_we = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
        ext_valid = 1'b1; ext_addr = 5'd0; ext_data = 32'hBEEF;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ext_ready !== 1'b1) begin
                n_fail++; $display("FAIL zero_ready: got %b, required 1", ext_ready);
            end
            tick;
            n_checks++;
            if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++;
                $display("FAIL zero_addr: got we %b count %0d, required 0 0", reg_we, fifo_count);
            end
        end
        alu_we = 1'b0; ext_valid = 1'b0;
    endtask

`ifdef WB_HAZARD_EN
    task automatic test_hazard;
        alu_we = 1'b1; alu_addr = 5'd11; alu_data = 32'h66;
        exp_q.push_back(wr_t'{5'd11, 32'h66});
        ext_valid = 1'b1; ext_addr = 5'd3; ext_data = 32'h77;
        tick;
        alu_we = 1'b0; ext_valid = 1'b0;
        chk_addr_1 = 5'd3; chk_addr_2 = 5'd11;
        #1;
        n_checks++;
        if (chk_hit_1 !== 1'b1 || chk_hit_2 !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_buffered: got hit1 %b hit2 %b, required 1 1", chk_hit_1, chk_hit_2);
        end
        exp_q.push_back(wr_t'{5'd3, 32'h77});
        tick;
        n_checks++;
        if (chk_hit_1 !== 1'b1 || chk_hit_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_writing: got hit1 %b hit2 %b, required 1 0", chk_hit_1, chk_hit_2);
        end
        tick;
        n_checks++;
        if (chk_hit_1 !== 1'b0) begin
            n_fail++; $display("FAIL hazard_done: got hit1 %b, required 0", chk_hit_1);
        end
        chk_addr_1 = '0; chk_addr_2 = '0;
    endtask
`endif

    task automatic test_reset_mid_buffer;
        alu_we = 1'b1; alu_addr = 5'd11; alu_data = 32'h66;
        exp_q.push_back(wr_t'{5'd11, 32'h66});
        ext_valid = 1'b1; ext_addr = 5'd3; ext_data = 32'h77;
        tick;
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL rst_buffered: got count %0d, required 1", fifo_count);
        end
        rst = 1'b1; alu_addr = 5'd13; alu_data = 32'h99; ext_addr = 5'd4;
        #1;
        n_checks++;
        if (ext_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready: got %b, required 0", ext_ready);
        end
        tick;
        rst = 1'b0; alu_we = 1'b0; ext_valid = 1'b0;
        n_checks++;
        if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got we %b count %0d, required 0 0", reg_we, fifo_count);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++;
            if (reg_we !== 1'b0) begin
                n_fail++; $display("FAIL rst_discard: got we %b addr %0d, required 0", reg_we, reg_addr_3);
            end
        end
    endtask

    task automatic test_drain;
        tick; tick;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_alu_write;
        test_bypass;
        test_starvation;
        test_kill;
        test_addr_zero;
`ifdef WB_HAZARD_EN
        test_hazard;
`endif
        test_reset_mid_buffer;
        test_drain;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
